da_lut_loader: RTL

- Hardware writer for the distributed-arithmetic coefficient LUT port (CIN/CADDR/CLOAD) of fir_filter.
- Accepts TAPS raw signed coefficients over a valid/ready stream.
- Computes every 2^GROUP-entry partial-sum table for each coefficient group.
- Streams the full table to the filter, replacing software precompute.
- Runs in the clk_fast domain; holds each entry long enough for the filter's clk_slow sampling.

---
 rtl/da_pkg.sv | 17 +
 rtl/da_group_sum.sv | 22 ++
 rtl/da_lut_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/da_pkg.sv
// Shared widths and state encoding for the distributed-arithmetic coefficient LUT.
// fir_filter imports the same constants, so CIN/CADDR widths agree on both sides.
package da_pkg;

    localparam int COEF_W = 16;
    localparam int TAPS   = 64;
    localparam int GROUP  = 8;
    localparam int LUT_W  = COEF_W + 3;
    localparam int ADDR_W = GROUP + $clog2(TAPS / GROUP);

    typedef enum logic [1:0] {
        COLLECT,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/da_group_sum.sv
// Combinational partial sum of one coefficient group: adds every coefficient whose
// mask bit is set, each sign-extended to the LUT width.
module da_group_sum
    import da_pkg::*;
(
    input  logic [GROUP*COEF_W-1:0] coefs,
    input  logic [GROUP-1:0]        mask,
    output logic [LUT_W-1:0]        sum
);

    // GROUP terms of COEF_W bits always fit in LUT_W, so plain wrap-free addition suffices.
    always_comb begin
        sum = '0;
        for (int b = 0; b < GROUP; b++) begin
            if (mask[b]) begin
                sum = sum + {{(LUT_W-COEF_W){coefs[b*COEF_W+COEF_W-1]}},
                             coefs[b*COEF_W +: COEF_W]};
            end
        end
    end

endmodule

// File: rtl/da_lut_loader.sv
// Collects TAPS signed coefficients, then writes every partial-sum entry of the DA LUT
// to fir_filter, holding each (CADDR, CIN) pair for HOLD_CYCLES clk_fast cycles.
module da_lut_loader
    import da_pkg::*;
#(
    parameter int HOLD_CYCLES = 192
) (
    input  logic              clk_fast,
    input  logic              reset,
    input  logic [COEF_W-1:0] coef_in,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic              restart,
    output logic [LUT_W-1:0]  CIN,
    output logic [ADDR_W-1:0] CADDR,
    output logic              CLOAD,
    output logic              busy,
    output logic              done
);

    // Tap index splits into {group, position}; assumes GROUP and TAPS/GROUP are powers of two.
    localparam int GB    = $clog2(GROUP);
    localparam int KW    = ADDR_W - GROUP;
    localparam int CNT_W = KW + GB;
    localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  LAST_TAP  = CNT_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [HW-1:0]     LAST_HOLD = HW'(HOLD_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [HW-1:0]       hold_cnt;
    logic [COEF_W-1:0]   coef_mem [TAPS/GROUP][GROUP];
    logic                take;
    logic [ADDR_W-1:0]   next_addr;
    logic [KW-1:0]       next_k;
    logic [GROUP*COEF_W-1:0] grp_coefs;
    logic [LUT_W-1:0]    next_cin;

    assign take = coef_valid && coef_ready && !restart && !reset;

    // Register file is deliberately left out of reset; only accepted transfers write it.
    always_ff @(posedge clk_fast) begin
        if (take) begin
            coef_mem[cnt[CNT_W-1:GB]][cnt[GB-1:0]] <= coef_in;
        end
    end

    // Entry for the following address is formed combinationally so it is ready even with HOLD_CYCLES==1.
    assign next_addr = CADDR + ADDR_W'(1);
    assign next_k    = next_addr[ADDR_W-1:GROUP];

    for (genvar b = 0; b < GROUP; b++) begin : g_mux
        assign grp_coefs[b*COEF_W +: COEF_W] = coef_mem[next_k][b];
    end

    da_group_sum u_group_sum (
        .coefs (grp_coefs),
        .mask  (next_addr[GROUP-1:0]),
        .sum   (next_cin)
    );

    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            state      <= COLLECT;
            cnt        <= '0;
            hold_cnt   <= '0;
            coef_ready <= 1'b1;
            CIN        <= '0;
            CADDR      <= '0;
            CLOAD      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (restart) begin
            state      <= COLLECT;
            cnt        <= '0;
            hold_cnt   <= '0;
            coef_ready <= 1'b1;
            CIN        <= '0;
            CADDR      <= '0;
            CLOAD      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (coef_valid) begin
                        if (cnt == LAST_TAP) begin
                            state      <= EMIT;
                            cnt        <= '0;
                            hold_cnt   <= '0;
                            coef_ready <= 1'b0;
                            CLOAD      <= 1'b1;
                            busy       <= 1'b1;
                            CADDR      <= '0;
                            CIN        <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                // Address and entry change together on the last hold cycle, so there is no gap.
                EMIT: begin
                    if (hold_cnt == LAST_HOLD) begin
                        hold_cnt <= '0;
                        if (CADDR == LAST_ADDR) begin
                            state <= DONE;
                            CLOAD <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            CADDR <= next_addr;
                            CIN   <= next_cin;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
